// File: rtl/data_mem_be_if.sv
// Request/response bus of the byte-enabled data memory.
// The master issues loads/stores; the slave answers one cycle after acceptance.
interface data_mem_be_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_wdata;
    logic [31:0] req_pc;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        busy;

    modport master (
        output req_valid, req_we, req_addr, req_size, req_unsigned, req_wdata, req_pc,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err, busy
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_size, req_unsigned, req_wdata, req_pc,
        output req_ready, rsp_valid, rsp_rdata, rsp_err, busy
    );
endinterface

// File: rtl/data_mem_be.sv
// Word-organised data memory with byte/half/word loads and stores.
// After reset the low CLR_WORDS words are zeroed one per cycle before requests are accepted.
module data_mem_be #(
    parameter int ADDR_W    = 10,
    parameter int CLR_WORDS = 32
) (
    input  logic         CLK,
    input  logic         Reset,
    data_mem_be_if.slave bus
);
    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] CLR_LAST = ADDR_W'(CLR_WORDS - 1);

    typedef enum logic {ST_CLEAR = 1'b0, ST_IDLE = 1'b1} state_t;

    state_t            state_r;
    state_t            state_nxt_s;
    logic [ADDR_W-1:0] clr_cnt_r;
    logic [ADDR_W-1:0] clr_cnt_nxt_s;
    logic [31:0]       mem_r [DEPTH] = '{default: 32'h0000_0000};

    logic [ADDR_W-1:0] req_idx_s;
    logic [1:0]        off_s;
    logic              accept_s;
    logic              err_s;
    logic [31:0]       rd_word_s;
    logic [31:0]       wr_rep_s;
    logic [31:0]       st_word_s;
    logic              mem_we_s;
    logic [ADDR_W-1:0] mem_idx_s;
    logic [31:0]       mem_wdata_s;
    logic              store_commit_s;

    logic              rsp_valid_r;
    logic              rsp_err_r;
    logic [31:0]       rsp_rdata_r;

    function automatic logic access_err(input logic [1:0] size, input logic [1:0] off);
        case (size)
            2'd0:    access_err = 1'b0;
            2'd1:    access_err = off[0];
            2'd2:    access_err = (off != 2'd0);
            default: access_err = 1'b1;
        endcase
    endfunction

    function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] off);
        case (size)
            2'd0:    lane_mask = 4'b0001 << off;
            2'd1:    lane_mask = off[1] ? 4'b1100 : 4'b0011;
            2'd2:    lane_mask = 4'b1111;
            default: lane_mask = 4'b0000;
        endcase
    endfunction

    function automatic logic [31:0] merge_lanes(input logic [31:0] old_w, input logic [31:0] new_w,
                                                input logic [3:0] mask);
        logic [31:0] m;
        for (int i = 0; i < 4; i++) begin
            m[8*i +: 8] = mask[i] ? new_w[8*i +: 8] : old_w[8*i +: 8];
        end
        return m;
    endfunction

    function automatic logic [31:0] load_extract(input logic [31:0] word, input logic [1:0] size,
                                                 input logic [1:0] off, input logic uns);
        logic [7:0]  b;
        logic [15:0] h;
        b = word[{off, 3'b000} +: 8];
        h = off[1] ? word[31:16] : word[15:0];
        case (size)
            2'd0:    load_extract = uns ? {24'h000000, b} : {{24{b[7]}}, b};
            2'd1:    load_extract = uns ? {16'h0000, h} : {{16{h[15]}}, h};
            2'd2:    load_extract = word;
            default: load_extract = 32'h0000_0000;
        endcase
    endfunction

    assign req_idx_s = bus.req_addr[ADDR_W+1:2];
    assign off_s     = bus.req_addr[1:0];
    assign accept_s  = bus.req_valid && (state_r == ST_IDLE);
    assign err_s     = access_err(bus.req_size, off_s);
    assign rd_word_s = mem_r[req_idx_s];

    // Store data replicated across lanes, then merged into the current word.
    always_comb begin
        wr_rep_s = bus.req_wdata;
        case (bus.req_size)
            2'd0:    wr_rep_s = {4{bus.req_wdata[7:0]}};
            2'd1:    wr_rep_s = {2{bus.req_wdata[15:0]}};
            default: wr_rep_s = bus.req_wdata;
        endcase
        st_word_s = merge_lanes(rd_word_s, wr_rep_s, lane_mask(bus.req_size, off_s));
    end

    // Next-state logic and memory write-port selection.
    always_comb begin
        state_nxt_s    = state_r;
        clr_cnt_nxt_s  = clr_cnt_r;
        mem_we_s       = 1'b0;
        mem_idx_s      = req_idx_s;
        mem_wdata_s    = st_word_s;
        store_commit_s = 1'b0;
        case (state_r)
            ST_CLEAR: begin
                mem_we_s    = 1'b1;
                mem_idx_s   = clr_cnt_r;
                mem_wdata_s = 32'h0000_0000;
                if (clr_cnt_r == CLR_LAST) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    clr_cnt_nxt_s = clr_cnt_r + ADDR_W'(1);
                end
            end
            ST_IDLE: begin
                if (accept_s && bus.req_we && !err_s) begin
                    mem_we_s       = 1'b1;
                    store_commit_s = 1'b1;
                end else begin
                    mem_we_s       = 1'b0;
                    store_commit_s = 1'b0;
                end
            end
            default: begin
                state_nxt_s   = ST_CLEAR;
                clr_cnt_nxt_s = '0;
            end
        endcase
    end

    // FSM state and clear counter.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            state_r   <= ST_CLEAR;
            clr_cnt_r <= '0;
        end else begin
            state_r   <= state_nxt_s;
            clr_cnt_r <= clr_cnt_nxt_s;
        end
    end

    // Single write port shared by the clear sequence and stores.
    always_ff @(posedge CLK) begin
        if (mem_we_s && !Reset) begin
            mem_r[mem_idx_s] <= mem_wdata_s;
        end
    end

    // Registered response, read data taken from the word as it was before this edge.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            rsp_valid_r <= 1'b0;
            rsp_err_r   <= 1'b0;
            rsp_rdata_r <= 32'h0000_0000;
        end else begin
            rsp_valid_r <= accept_s;
            rsp_err_r   <= accept_s && err_s;
            rsp_rdata_r <= (accept_s && !err_s && !bus.req_we) ?
                           load_extract(rd_word_s, bus.req_size, off_s, bus.req_unsigned) :
                           32'h0000_0000;
        end
    end

`ifndef SYNTHESIS
    // Store trace for simulation.
    always_ff @(posedge CLK) begin
        if (store_commit_s && !Reset) begin
            $display("%d@%h: *%h <= %h", $time, bus.req_pc, {bus.req_addr[31:2], 2'b00}, st_word_s);
        end
    end
`endif

    assign bus.req_ready = (state_r == ST_IDLE);
    assign bus.busy      = (state_r == ST_CLEAR);
    assign bus.rsp_valid = rsp_valid_r;
    assign bus.rsp_err   = rsp_err_r;
    assign bus.rsp_rdata = rsp_rdata_r;
endmodule

// File: tb/tb_data_mem_be.sv
// Directed bench for data_mem_be: expected responses are queued at issue time
// and compared when rsp_valid is seen.
module tb_data_mem_be;
    logic CLK   = 1'b0;
    logic Reset = 1'b1;
    always #5 CLK = ~CLK;

    data_mem_be_if bus();

    data_mem_be #(.ADDR_W(10), .CLR_WORDS(32)) dut (
        .CLK  (CLK),
        .Reset(Reset),
        .bus  (bus)
    );

    int          n_assert = 0;
    int          n_fail   = 0;
    logic [32:0] exp_q[$];
    string       tag_q[$];
    logic [32:0] exp_e;
    string       exp_t;
    logic [31:0] pc = 32'h0000_1000;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Response scoreboard.
    always @(negedge CLK) begin
        if (bus.rsp_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_rsp", {31'd0, bus.rsp_valid}, 32'd0);
            end else begin
                exp_e = exp_q.pop_front();
                exp_t = tag_q.pop_front();
                check({exp_t, "_err"}, {31'd0, bus.rsp_err}, {31'd0, exp_e[32]});
                check({exp_t, "_rdata"}, bus.rsp_rdata, exp_e[31:0]);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: observed no finish expected finish");
        $fatal(1, "timeout");
    end

    task automatic idle();
        bus.req_valid    = 1'b0;
        bus.req_we       = 1'b0;
        bus.req_addr     = 32'h0;
        bus.req_size     = 2'd0;
        bus.req_unsigned = 1'b0;
        bus.req_wdata    = 32'h0;
        bus.req_pc       = 32'h0;
    endtask

    task automatic issue(input string tag, input logic we, input logic [31:0] addr,
                         input logic [1:0] size, input logic uns, input logic [31:0] wdata,
                         input logic [31:0] exp_rdata, input logic exp_err);
        int w = 0;
        while (bus.req_ready !== 1'b1 && w < 100) begin
            @(negedge CLK);
            w++;
        end
        check({tag, "_ready"}, {31'd0, bus.req_ready}, 32'd1);
        bus.req_valid    = 1'b1;
        bus.req_we       = we;
        bus.req_addr     = addr;
        bus.req_size     = size;
        bus.req_unsigned = uns;
        bus.req_wdata    = wdata;
        bus.req_pc       = pc;
        pc               = pc + 32'd4;
        exp_q.push_back({exp_err, exp_rdata});
        tag_q.push_back(tag);
        @(negedge CLK);
    endtask

    task automatic st(input string tag, input logic [31:0] addr, input logic [1:0] size,
                      input logic [31:0] wdata, input logic exp_err);
        issue(tag, 1'b1, addr, size, 1'b0, wdata, 32'h0, exp_err);
    endtask

    task automatic ld(input string tag, input logic [31:0] addr, input logic [1:0] size,
                      input logic uns, input logic [31:0] exp_rdata, input logic exp_err);
        issue(tag, 1'b0, addr, size, uns, 32'hA5A5_A5A5, exp_rdata, exp_err);
    endtask

    task automatic count_busy(input string tag, input int exp_n);
        int n = 0;
        while (bus.busy === 1'b1 && n < 200) begin
            check({tag, "_ready_low"}, {31'd0, bus.req_ready}, 32'd0);
            n++;
            @(negedge CLK);
        end
        check({tag, "_busy_cycles"}, n, exp_n);
    endtask

    task automatic pulse_reset();
        idle();
        Reset = 1'b1;
        @(negedge CLK);
        Reset = 1'b0;
    endtask

    initial begin
        idle();
        Reset = 1'b1;
        repeat (3) @(negedge CLK);
        check("rst_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
        check("rst_rsp_err",   {31'd0, bus.rsp_err},   32'd0);
        check("rst_rsp_rdata", bus.rsp_rdata,          32'd0);
        check("rst_busy",      {31'd0, bus.busy},      32'd1);
        check("rst_ready",     {31'd0, bus.req_ready}, 32'd0);
        Reset = 1'b0;
        count_busy("clear1", 32);
        ld("lw_word5", 32'h14, 2'd2, 1'b0, 32'h0, 1'b0);

        // Lane extraction from a single word.
        st("sw_10",     32'h10, 2'd2, 32'h1122_3344, 1'b0);
        ld("lb_13",     32'h13, 2'd0, 1'b0, 32'h0000_0011, 1'b0);
        ld("lbu_10",    32'h10, 2'd0, 1'b1, 32'h0000_0044, 1'b0);
        ld("lh_12",     32'h12, 2'd1, 1'b0, 32'h0000_1122, 1'b0);
        ld("lhu_10",    32'h10, 2'd1, 1'b1, 32'h0000_3344, 1'b0);
        ld("lb_12",     32'h12, 2'd0, 1'b0, 32'h0000_0022, 1'b0);

        // Partial stores and sign extension.
        st("sw_20",     32'h20, 2'd2, 32'h0000_00FF, 1'b0);
        st("sb_21",     32'h21, 2'd0, 32'h1234_5680, 1'b0);
        ld("lb_21",     32'h21, 2'd0, 1'b0, 32'hFFFF_FF80, 1'b0);
        ld("lbu_21",    32'h21, 2'd0, 1'b1, 32'h0000_0080, 1'b0);
        ld("lw_20",     32'h20, 2'd2, 1'b1, 32'h0000_80FF, 1'b0);
        st("sh_22",     32'h22, 2'd1, 32'h7777_BEEF, 1'b0);
        ld("lh_22",     32'h22, 2'd1, 1'b0, 32'hFFFF_BEEF, 1'b0);
        ld("lw_20b",    32'h20, 2'd2, 1'b0, 32'hBEEF_80FF, 1'b0);

        // Misaligned and illegal accesses.
        st("sh_01_err", 32'h01, 2'd1, 32'h0000_5555, 1'b1);
        st("sw_22_err", 32'h22, 2'd2, 32'h6666_6666, 1'b1);
        ld("sz3_err",   32'h20, 2'd3, 1'b0, 32'h0, 1'b1);
        ld("lh_11_err", 32'h11, 2'd1, 1'b0, 32'h0, 1'b1);
        ld("lw_20_chk", 32'h20, 2'd2, 1'b0, 32'hBEEF_80FF, 1'b0);
        ld("lw_00_chk", 32'h00, 2'd2, 1'b0, 32'h0, 1'b0);

        // Store followed by load on the next cycle.
        st("b2b_sw", 32'h30, 2'd2, 32'hCAFE_F00D, 1'b0);
        check("b2b_valid1", {31'd0, bus.rsp_valid}, 32'd1);
        ld("b2b_lw", 32'h30, 2'd2, 1'b0, 32'hCAFE_F00D, 1'b0);
        check("b2b_valid2", {31'd0, bus.rsp_valid}, 32'd1);
        st("b2b_sb", 32'h33, 2'd0, 32'h0000_0012, 1'b0);
        ld("b2b_lbu", 32'h33, 2'd0, 1'b1, 32'h0000_0012, 1'b0);
        idle();
        @(negedge CLK);
        check("b2b_valid_drop", {31'd0, bus.rsp_valid}, 32'd0);

        // Address wrap modulo depth.
        st("sw_wrap", 32'h1000, 2'd2, 32'hDEAD_BEEF, 1'b0);
        ld("lw_wrap", 32'h0,    2'd2, 1'b0, 32'hDEAD_BEEF, 1'b0);

        // Data inside and outside the cleared region across a reset.
        st("sw_w5",  32'h14,  2'd2, 32'h5A5A_5A5A, 1'b0);
        st("sw_w31", 32'h7C,  2'd2, 32'h0000_0001, 1'b0);
        st("sw_w32", 32'h80,  2'd2, 32'h0000_0077, 1'b0);
        st("sw_w64", 32'h100, 2'd2, 32'h1234_5678, 1'b0);
        idle();
        repeat (2) @(negedge CLK);

        // Reset restarted at clear count 10 while a store is held on the bus.
        pulse_reset();
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b1;
        bus.req_addr  = 32'hA0;
        bus.req_size  = 2'd2;
        bus.req_wdata = 32'h9999_9999;
        for (int i = 0; i < 10; i++) begin
            check("clear2_busy", {31'd0, bus.busy}, 32'd1);
            @(negedge CLK);
        end
        pulse_reset();
        count_busy("clear3", 32);

        ld("post_w5",  32'h14,  2'd2, 1'b0, 32'h0, 1'b0);
        ld("post_w31", 32'h7C,  2'd2, 1'b0, 32'h0, 1'b0);
        ld("post_w0",  32'h0,   2'd2, 1'b0, 32'h0, 1'b0);
        ld("post_w32", 32'h80,  2'd2, 1'b0, 32'h0000_0077, 1'b0);
        ld("post_w64", 32'h100, 2'd2, 1'b0, 32'h1234_5678, 1'b0);
        ld("post_w40", 32'hA0,  2'd2, 1'b0, 32'h0, 1'b0);
        idle();
        repeat (3) @(negedge CLK);
        check("queue_drained", exp_q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
